// File: rtl/pointer_sequencer_pkg.sv
// ============================================================================
//  Module      : pointer_sequencer_pkg
//  Description : Shared constants for the matrix pointer sequencer: FSM state
//                encoding and default count width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pointer_sequencer_pkg;

    localparam int DEFAULT_W = 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pointer_sequencer_if.sv
// ============================================================================
//  Module      : pointer_sequencer_if
//  Description : Processor-side bus and pointer strobe bundle for the
//                matrix pointer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import pointer_sequencer_pkg::*;

interface pointer_sequencer_if #(
    parameter int W = DEFAULT_W
);
    logic [W-1:0] BusOut;
    logic         Wen_R;
    logic         Wen_C;
    logic         Start;
    logic         Step;
    logic         CP_INC;
    logic         CP_REW;
    logic         RP_INC;
    logic         RP_REW;
    logic         Busy;
    logic         Done;
    logic         Err;
    logic         Col_last;
    logic         Row_last;

    modport master (
        output BusOut, Wen_R, Wen_C, Start, Step,
        input  CP_INC, CP_REW, RP_INC, RP_REW, Busy, Done, Err, Col_last, Row_last
    );

    modport slave (
        input  BusOut, Wen_R, Wen_C, Start, Step,
        output CP_INC, CP_REW, RP_INC, RP_REW, Busy, Done, Err, Col_last, Row_last
    );
endinterface

`default_nettype wire

// File: rtl/pointer_sequencer_tc_counter.sv
// ============================================================================
//  Module      : tc_counter
//  Description : W-bit up counter with synchronous clear and a terminal
//                compare flag (count == limit - 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import pointer_sequencer_pkg::*;

module tc_counter #(
    parameter int W = DEFAULT_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_inc,
    input  wire logic [W-1:0] i_limit,
    output logic              o_tc
);
    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Count up on increment; clear takes priority so a wrap-to-zero rewind wins.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Terminal compare in W-bit unsigned arithmetic; the counter never passes limit-1.
    assign o_tc = (r_cnt == (i_limit - c_ONE));

endmodule

`default_nettype wire

// File: rtl/pointer_sequencer.sv
// ============================================================================
//  Module      : pointer_sequencer
//  Description : Walks a rows x cols matrix one element per Step, issuing
//                registered increment/rewind strobes to the column and row
//                pointer registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import pointer_sequencer_pkg::*;

module pointer_sequencer #(
    parameter int W = DEFAULT_W
) (
    input  wire logic          Clk,
    input  wire logic          RST,
    pointer_sequencer_if.slave bus
);
    logic [W-1:0] r_rows;
    logic [W-1:0] r_cols;
    logic [1:0]   r_state;
    logic [1:0]   w_next;

    logic w_idle, w_run, w_done_st, w_start_ok, w_adv, w_c_tc, w_r_tc;
    logic w_c_clr, w_c_inc, w_r_clr, w_r_inc;
    logic w_cp_inc, w_cp_rew, w_rp_inc, w_rp_rew, w_err, w_busy, w_done;
    logic r_cp_inc, r_cp_rew, r_rp_inc, r_rp_rew, r_err, r_busy, r_done;

    assign w_idle     = (r_state == c_ST_IDLE);
    assign w_run      = (r_state == c_ST_RUN);
    assign w_done_st  = (r_state == c_ST_DONE);
    assign w_start_ok = bus.Start && (r_rows != '0) && (r_cols != '0);
    assign w_adv      = w_run && bus.Step;

    // Dimension registers; a Start in the same cycle still sees the old values.
    always_ff @(posedge Clk) begin
        if (RST) begin
            r_rows <= '0;
            r_cols <= '0;
        end else begin
            if (bus.Wen_R) r_rows <= bus.BusOut;
            if (bus.Wen_C) r_cols <= bus.BusOut;
        end
    end

    // Counter control: both cleared on a good Start, column rewinds at row end.
    assign w_c_clr = (w_idle && w_start_ok) || (w_adv && w_c_tc);
    assign w_c_inc = w_adv && !w_c_tc;
    assign w_r_clr = w_idle && w_start_ok;
    assign w_r_inc = w_adv && w_c_tc && !w_r_tc;

    tc_counter #(.W(W)) u_col_cnt (
        .clk     (Clk),
        .rst     (RST),
        .i_clr   (w_c_clr),
        .i_inc   (w_c_inc),
        .i_limit (r_cols),
        .o_tc    (w_c_tc)
    );

    tc_counter #(.W(W)) u_row_cnt (
        .clk     (Clk),
        .rst     (RST),
        .i_clr   (w_r_clr),
        .i_inc   (w_r_inc),
        .i_limit (r_rows),
        .o_tc    (w_r_tc)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (RST) r_state <= c_ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: Start only matters in IDLE, Step only in RUN, DONE is one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_ok) w_next = c_ST_RUN;
            c_ST_RUN:  if (w_adv && w_c_tc && w_r_tc) w_next = c_ST_DONE;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes and flags.
    always_comb begin
        w_cp_inc = w_adv && !w_c_tc;
        w_cp_rew = w_adv && w_c_tc;
        w_rp_inc = w_adv && w_c_tc && !w_r_tc;
        w_rp_rew = w_adv && w_c_tc && w_r_tc;
        w_err    = w_idle && bus.Start && !w_start_ok;
        w_busy   = (w_next == c_ST_RUN);
        w_done   = w_done_st;
    end

    // Output registers; each strobe is a single-cycle pulse.
    always_ff @(posedge Clk) begin
        if (RST) begin
            r_cp_inc <= 1'b0;
            r_cp_rew <= 1'b0;
            r_rp_inc <= 1'b0;
            r_rp_rew <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cp_inc <= w_cp_inc;
            r_cp_rew <= w_cp_rew;
            r_rp_inc <= w_rp_inc;
            r_rp_rew <= w_rp_rew;
            r_err    <= w_err;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign bus.CP_INC   = r_cp_inc;
    assign bus.CP_REW   = r_cp_rew;
    assign bus.RP_INC   = r_rp_inc;
    assign bus.RP_REW   = r_rp_rew;
    assign bus.Err      = r_err;
    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.Col_last = w_run && w_c_tc;
    assign bus.Row_last = w_run && w_r_tc;

endmodule

`default_nettype wire

// File: tb/tb_pointer_sequencer.sv
// ============================================================================
//  Module      : tb_pointer_sequencer
//  Description : Directed and randomized bench for pointer_sequencer against
//                an element-index reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pointer_sequencer;

    logic Clk = 1'b0;
    logic RST;

    always #5 Clk = ~Clk;

    pointer_sequencer_if #(.W(8)) bus ();

    pointer_sequencer #(.W(8)) dut (
        .Clk (Clk),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: walk position as a linear element index idx = row*cols + col.
    int m_mode = 0;   // 0 idle, 1 walking, 2 walk just finished
    int m_rows = 0;
    int m_cols = 0;
    int m_idx  = 0;
    bit e_cpi, e_cpr, e_rpi, e_rpr, e_err, e_done;

    task automatic model_step();
        if (RST) begin
            m_mode = 0; m_rows = 0; m_cols = 0; m_idx = 0;
            e_cpi = 0; e_cpr = 0; e_rpi = 0; e_rpr = 0; e_err = 0; e_done = 0;
        end else begin
            e_done = (m_mode == 2);
            e_cpi = 0; e_cpr = 0; e_rpi = 0; e_rpr = 0; e_err = 0;
            case (m_mode)
                0: if (bus.Start) begin
                       if (m_rows != 0 && m_cols != 0) begin
                           m_mode = 1;
                           m_idx  = 0;
                       end else begin
                           e_err = 1;
                       end
                   end
                1: if (bus.Step) begin
                       m_idx++;
                       if (m_idx == m_rows * m_cols) begin
                           e_cpr = 1; e_rpr = 1; m_mode = 2;
                       end else if (m_idx % m_cols == 0) begin
                           e_cpr = 1; e_rpi = 1;
                       end else begin
                           e_cpi = 1;
                       end
                   end
                default: m_mode = 0;
            endcase
            if (bus.Wen_R) m_rows = int'(bus.BusOut);
            if (bus.Wen_C) m_cols = int'(bus.BusOut);
        end
    endtask

    function automatic logic [8:0] expected();
        bit busy, cl, rl;
        busy = (m_mode == 1);
        cl   = 0;
        rl   = 0;
        if (busy) begin
            cl = (m_idx % m_cols == m_cols - 1);
            rl = (m_idx / m_cols == m_rows - 1);
        end
        return {e_cpi, e_cpr, e_rpi, e_rpr, busy, e_done, e_err, cl, rl};
    endfunction

    task automatic check(input string tag);
        logic [8:0] obs, exp;
        obs = {bus.CP_INC, bus.CP_REW, bus.RP_INC, bus.RP_REW, bus.Busy,
               bus.Done, bus.Err, bus.Col_last, bus.Row_last};
        exp = expected();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (cpi,cpr,rpi,rpr,busy,done,err,cl,rl)",
                   tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic drive(input logic rst, input logic [7:0] d, input logic wr,
                         input logic wc, input logic st, input logic sp);
        RST        = rst;
        bus.BusOut = d;
        bus.Wen_R  = wr;
        bus.Wen_C  = wc;
        bus.Start  = st;
        bus.Step   = sp;
    endtask

    initial begin
        int inc_seen;
        logic [7:0] d;
        logic       rr, st, sp, wr, wc;

        drive(1, 8'd0, 0, 0, 1, 1);
        tick("reset");
        tick("reset_hold");

        // 2x3 walk with Steps spaced by idle cycles
        drive(0, 8'd2, 1, 0, 0, 0); tick("load_r2");
        drive(0, 8'd3, 0, 1, 0, 0); tick("load_c3");
        drive(0, 8'd0, 0, 0, 1, 0); tick("start_2x3");
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'd0, 0, 0, 0, 1); tick("step_2x3");
            drive(0, 8'd0, 0, 0, 0, 0); tick("gap_2x3");
        end
        drive(0, 8'd0, 0, 0, 0, 0); tick("done_2x3");
        tick("idle_2x3");

        // 1x1 walk
        drive(0, 8'd1, 1, 1, 0, 0); tick("load_1x1");
        drive(0, 8'd0, 0, 0, 1, 0); tick("start_1x1");
        drive(0, 8'd0, 0, 0, 0, 1); tick("step_1x1");
        drive(0, 8'd0, 0, 0, 0, 0); tick("done_1x1");
        tick("idle_1x1");

        // zero column count rejected
        drive(0, 8'd0, 0, 1, 0, 0); tick("load_c0");
        drive(0, 8'd0, 0, 0, 1, 0); tick("start_err");
        drive(0, 8'd0, 0, 0, 0, 1); tick("after_err");
        tick("after_err2");

        // reset in the middle of a 3x4 walk
        drive(0, 8'd3, 1, 0, 0, 0); tick("load_r3");
        drive(0, 8'd4, 0, 1, 0, 0); tick("load_c4");
        drive(0, 8'd0, 0, 0, 1, 0); tick("start_3x4");
        for (int i = 0; i < 5; i++) begin
            drive(0, 8'd0, 0, 0, 0, 1); tick("step_3x4");
        end
        drive(1, 8'd0, 0, 0, 1, 1); tick("rst_mid_run");
        drive(0, 8'd0, 0, 0, 0, 1); tick("step_after_rst");
        drive(0, 8'd0, 0, 0, 0, 0); tick("idle_after_rst");

        // 1x255 walk with Step held high
        drive(0, 8'd1,   1, 0, 0, 0); tick("load_r1");
        drive(0, 8'd255, 0, 1, 0, 0); tick("load_c255");
        drive(0, 8'd0,   0, 0, 1, 0); tick("start_1x255");
        inc_seen = 0;
        drive(0, 8'd0, 0, 0, 0, 1);
        for (int i = 0; i < 255; i++) begin
            tick("step_1x255");
            if (bus.CP_INC) inc_seen++;
        end
        drive(0, 8'd0, 0, 0, 0, 0); tick("done_1x255");
        tick("idle_1x255");
        vectors++;
        assert (inc_seen == 254) else begin
            miscompares++;
            $error("FAIL cp_inc_run_1x255: observed %0d expected 254", inc_seen);
        end

        // Start coincident with a column load uses the old (zero) count
        drive(0, 8'd0, 0, 1, 0, 0); tick("load_c0_b");
        drive(0, 8'd5, 0, 1, 1, 0); tick("start_with_load");
        drive(0, 8'd0, 0, 0, 0, 0); tick("gap_load");
        drive(0, 8'd0, 0, 0, 1, 0); tick("start_c5");
        drive(0, 8'd0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick("step_1x5");
        drive(0, 8'd0, 0, 0, 0, 0); tick("done_1x5");
        tick("idle_1x5");

        // randomized traffic; count loads only outside an active walk
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = 1'($urandom_range(0, 1));
            wr = 1'b0;
            wc = 1'b0;
            if (m_mode != 1 && !st) begin
                wr = ($urandom_range(0, 3) == 0);
                wc = ($urandom_range(0, 3) == 0);
            end
            d = 8'($urandom_range(0, 4));
            drive(rr, d, wr, wc, st, sp);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
